// File: rtl/fir_ctrl.sv
// fir_ctrl -- sequencing controller for a 4-tap FIR datapath.
//
// A prescaler divides clk down to the sample rate. Each sample tick latches
// x_in into fir_x and pulses fir_en on the following cycle. y_valid follows
// fir_en by one cycle, because the datapath registers its output on en.
// Coefficients are written into a shadow bank at any time. A commit copies
// the whole bank to the active outputs b0..b3 at a safe point. That point is
// the next cycle when idle, or the next sample tick when streaming.
//
// Handshake: fir_en and y_valid are single-cycle qualifiers with no
// backpressure. A consumer must take fir_x / its output on the cycle the
// pulse is high.
//
// Optional feature, macro FIR_CTRL_FLUSH_EN:
//   defined   -> stop in RUN enters FLUSH, which pushes 4 zero samples
//                through the taps before returning to IDLE.
//   undefined -> stop in RUN returns straight to IDLE; FLUSH is not built.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   start, stop       one-cycle stream requests
//   div               sample period minus one, in clk cycles
//   x_in              input sample, captured on each tick
//   cfg_we/addr/wdata shadow coefficient write port
//   commit            request to copy the shadow bank to the active bank
//   fir_en, fir_x     datapath enable pulse and registered sample
//   b0..b3            active coefficients
//   y_valid           datapath output valid pulse
//   busy              state is not IDLE
//   commit_pending    commit requested but not yet applied
//   state_dbg         raw FSM state, for observation only
module fir_ctrl #(
  parameter int N  = 16,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          stop,
  input  logic [DW-1:0] div,
  input  logic [N-1:0]  x_in,
  input  logic          cfg_we,
  input  logic [1:0]    cfg_addr,
  input  logic [N-1:0]  cfg_wdata,
  input  logic          commit,
  output logic          fir_en,
  output logic [N-1:0]  fir_x,
  output logic [N-1:0]  b0,
  output logic [N-1:0]  b1,
  output logic [N-1:0]  b2,
  output logic [N-1:0]  b3,
  output logic          y_valid,
  output logic          busy,
  output logic          commit_pending,
  output logic [1:0]    state_dbg
);

  typedef enum logic [1:0] {
`ifdef FIR_CTRL_FLUSH_EN
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
`else
    IDLE  = 2'd0,
    RUN   = 2'd1
`endif
  } state_t;

  state_t        state;
  logic [DW-1:0] cnt;
  logic [DW-1:0] div_q;
  logic [N-1:0]  shadow      [4];
  logic [N-1:0]  active      [4];
  logic [N-1:0]  shadow_next [4];
  logic          tick;
  logic          sample_tick;
  logic          copy_now;

`ifdef FIR_CTRL_FLUSH_EN
  logic [2:0]    fl_cnt;
  logic          flush_done;
`endif

  // div is held in div_q between wraps. Changing div mid-period therefore
  // only affects the next period.
  assign tick = (state != IDLE) && (cnt == div_q);

  // sample_tick is a tick that actually issues a sample. A tick that lands
  // on the stop cycle is dropped. So is any tick after the 4th flush sample.
`ifdef FIR_CTRL_FLUSH_EN
  assign flush_done  = (fl_cnt == 3'd4);
  assign sample_tick = tick && (((state == RUN) && !stop) ||
                                ((state == FLUSH) && !flush_done));
`else
  assign sample_tick = tick && (state == RUN) && !stop;
`endif

  // The copy is tied to a sample tick, so new coefficients appear on the
  // same edge as the fir_x they apply to.
  assign copy_now = commit_pending && ((state == IDLE) || sample_tick);

  // The shadow bank as it will be after this cycle's write. The copy reads
  // this value, so a write in the copy cycle is not lost.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      shadow_next[i] = shadow[i];
      if (cfg_we && (cfg_addr == 2'(i))) shadow_next[i] = cfg_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      cnt            <= '0;
      div_q          <= '0;
      fir_en         <= 1'b0;
      y_valid        <= 1'b0;
      fir_x          <= '0;
      commit_pending <= 1'b0;
      // b0 = 16 with the other taps zero is unity gain after the >>4.
      for (int i = 0; i < 4; i++) begin
        shadow[i] <= (i == 0) ? N'(16) : N'(0);
        active[i] <= (i == 0) ? N'(16) : N'(0);
      end
`ifdef FIR_CTRL_FLUSH_EN
      fl_cnt         <= '0;
`endif
    end else begin
      fir_en  <= 1'b0;
      y_valid <= fir_en;

      for (int i = 0; i < 4; i++) shadow[i] <= shadow_next[i];

      // The copy wins over a new commit, so a repeat commit is absorbed.
      if (copy_now) begin
        for (int i = 0; i < 4; i++) active[i] <= shadow_next[i];
        commit_pending <= 1'b0;
      end else if (commit) begin
        commit_pending <= 1'b1;
      end

      // Prescaler. It runs in RUN and FLUSH. The IDLE arm below holds it at 0.
      if (tick) begin
        cnt   <= '0;
        div_q <= div;
      end else if (state != IDLE) begin
        cnt <= cnt + DW'(1);
      end

      case (state)
        IDLE: begin
          cnt <= '0;
          // If start and stop arrive together, stop wins.
          if (start && !stop) begin
            state <= RUN;
            div_q <= div;
          end
        end
        RUN: begin
          if (stop) begin
`ifdef FIR_CTRL_FLUSH_EN
            state  <= FLUSH;
            fl_cnt <= '0;
`else
            state  <= IDLE;
            cnt    <= '0;
`endif
          end else if (tick) begin
            fir_x  <= x_in;
            fir_en <= 1'b1;
          end
        end
`ifdef FIR_CTRL_FLUSH_EN
        FLUSH: begin
          // flush_done is true during the 4th flush fir_en cycle. The FSM
          // leaves right after it.
          if (flush_done) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (tick) begin
            fir_x  <= '0;
            fir_en <= 1'b1;
            fl_cnt <= fl_cnt + 3'd1;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

  assign b0             = active[0];
  assign b1             = active[1];
  assign b2             = active[2];
  assign b3             = active[3];
  assign busy           = (state != IDLE);
  assign state_dbg      = state;

endmodule

// File: tb/tb_fir_ctrl.sv
// Self-checking bench for fir_ctrl. A negedge monitor logs fir_en, fir_x,
// y_valid, busy and x_in by cycle number. Each streaming task builds the
// expected fir_en schedule directly from the sample period: a tick every
// div+1 cycles after the start cycle, and a sample one cycle later. That
// schedule is compared against the log. The commit tasks keep a shadow and
// active coefficient model and check b0..b3 and commit_pending cycle by
// cycle.
module tb_fir_ctrl;
  localparam int N  = 16;
  localparam int DW = 16;
  localparam int HW = 8192;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          stop;
  logic [DW-1:0] div;
  logic [N-1:0]  x_in;
  logic          cfg_we;
  logic [1:0]    cfg_addr;
  logic [N-1:0]  cfg_wdata;
  logic          commit;
  logic          fir_en;
  logic [N-1:0]  fir_x;
  logic [N-1:0]  b0;
  logic [N-1:0]  b1;
  logic [N-1:0]  b2;
  logic [N-1:0]  b3;
  logic          y_valid;
  logic          busy;
  logic          commit_pending;
  logic [1:0]    state_dbg;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  logic [N-1:0] x_hist    [HW];
  logic         busy_hist [HW];
  int           en_cyc_q[$];
  logic [N-1:0] en_x_q[$];
  int           yv_cyc_q[$];
  int           exp_cyc_q[$];
  logic [N-1:0] exp_q[$];
  logic [N-1:0] sh_m  [4];
  logic [N-1:0] act_m [4];
  bit           x_fixed_en;
  logic [N-1:0] x_fixed;

  fir_ctrl #(.N(N), .DW(DW)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .stop           (stop),
    .div            (div),
    .x_in           (x_in),
    .cfg_we         (cfg_we),
    .cfg_addr       (cfg_addr),
    .cfg_wdata      (cfg_wdata),
    .commit         (commit),
    .fir_en         (fir_en),
    .fir_x          (fir_x),
    .b0             (b0),
    .b1             (b1),
    .b2             (b2),
    .b3             (b3),
    .y_valid        (y_valid),
    .busy           (busy),
    .commit_pending (commit_pending),
    .state_dbg      (state_dbg)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    x_hist[cyc % HW]    <= x_in;
    busy_hist[cyc % HW] <= busy;
    if (fir_en === 1'b1) begin
      en_cyc_q.push_back(cyc);
      en_x_q.push_back(fir_x);
    end
    if (y_valid === 1'b1) yv_cyc_q.push_back(cyc);
  end

  // ---------------- driver ----------------
  // Drives one cycle of inputs just after the rising edge. On return, cyc is
  // the number of the cycle these inputs belong to.
  task automatic step(input bit s, input bit p, input bit c,
                      input bit we = 1'b0, input logic [1:0] a = 2'd0,
                      input logic [N-1:0] wd = '0);
    @(posedge clk);
    #1;
    start     = s;
    stop      = p;
    commit    = c;
    cfg_we    = we;
    cfg_addr  = a;
    cfg_wdata = wd;
    x_in      = x_fixed_en ? x_fixed : N'($urandom);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      sh_m[i]  = (i == 0) ? N'(16) : N'(0);
      act_m[i] = sh_m[i];
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (fir_en !== 1'b0 || y_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_pulses: got fir_en=%b y_valid=%b expected 0 0", fir_en, y_valid);
    end
    vectors++;
    if (fir_x !== '0 || busy !== 1'b0 || commit_pending !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: got fir_x=%0d busy=%b pend=%b expected 0 0 0",
               fir_x, busy, commit_pending);
    end
    vectors++;
    if ({b0, b1, b2, b3} !== {N'(16), N'(0), N'(0), N'(0)}) begin
      miscompares++;
      $display("FAIL reset_coef: got %0d %0d %0d %0d expected 16 0 0 0", b0, b1, b2, b3);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_stream(input int d, input int run_len, input string name);
    int t0, s, k, t, busy_end, n;
    div = DW'(d);
    en_cyc_q.delete(); en_x_q.delete(); yv_cyc_q.delete();
    exp_cyc_q.delete(); exp_q.delete();
    step(1, 0, 0);
    t0 = cyc;
    // A start pulse partway through the stream must be ignored.
    for (int i = 1; i <= run_len; i++) step(i == 3, 0, 0);
    step(0, 1, 0);
    s = cyc;
    step(0, 1, 0);
    repeat (4 * (d + 1) + 8) step(0, 0, 0);
    @(negedge clk);
    @(negedge clk);

    // Ticks fall at t0 + k*(d+1). A tick before the stop cycle yields a sample.
    k = 1;
    t = t0;
    while (t0 + k * (d + 1) < s) begin
      t = t0 + k * (d + 1);
      exp_cyc_q.push_back(t + 1);
      exp_q.push_back(x_hist[t % HW]);
      k++;
    end
`ifdef FIR_CTRL_FLUSH_EN
    if (t0 + k * (d + 1) == s) k++;
    for (int j = 0; j < 4; j++) begin
      t = t0 + (k + j) * (d + 1);
      exp_cyc_q.push_back(t + 1);
      exp_q.push_back('0);
    end
    busy_end = t + 2;
`else
    busy_end = s + 1;
`endif

    vectors++;
    if (en_cyc_q.size() != exp_cyc_q.size()) begin
      miscompares++;
      $display("FAIL %s fir_en_count: got %0d expected %0d", name, en_cyc_q.size(), exp_cyc_q.size());
    end
    n = (en_cyc_q.size() < exp_cyc_q.size()) ? en_cyc_q.size() : exp_cyc_q.size();
    for (int i = 0; i < n; i++) begin
      vectors++;
      if (en_cyc_q[i] != exp_cyc_q[i] || en_x_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL %s fir_en[%0d]: got cyc+%0d x=%0d expected cyc+%0d x=%0d",
                 name, i, en_cyc_q[i] - t0, en_x_q[i], exp_cyc_q[i] - t0, exp_q[i]);
      end
    end
    vectors++;
    if (yv_cyc_q.size() != exp_cyc_q.size()) begin
      miscompares++;
      $display("FAIL %s y_valid_count: got %0d expected %0d", name, yv_cyc_q.size(), exp_cyc_q.size());
    end
    n = (yv_cyc_q.size() < exp_cyc_q.size()) ? yv_cyc_q.size() : exp_cyc_q.size();
    for (int i = 0; i < n; i++) begin
      vectors++;
      if (yv_cyc_q[i] != exp_cyc_q[i] + 1) begin
        miscompares++;
        $display("FAIL %s y_valid[%0d]: got cyc+%0d expected cyc+%0d",
                 name, i, yv_cyc_q[i] - t0, exp_cyc_q[i] + 1 - t0);
      end
    end
    vectors++;
    if (busy_hist[t0 % HW] !== 1'b0 || busy_hist[(t0 + 1) % HW] !== 1'b1) begin
      miscompares++;
      $display("FAIL %s busy_rise: got %b%b expected 01", name,
               busy_hist[t0 % HW], busy_hist[(t0 + 1) % HW]);
    end
    vectors++;
    if (busy_hist[(busy_end - 1) % HW] !== 1'b1 || busy_hist[busy_end % HW] !== 1'b0) begin
      miscompares++;
      $display("FAIL %s busy_fall: got %b%b expected 10 at stop+%0d", name,
               busy_hist[(busy_end - 1) % HW], busy_hist[busy_end % HW], busy_end - s);
    end
  endtask

  task automatic test_commit_idle();
    logic [N-1:0] w;
    for (int a = 0; a < 4; a++) begin
      sh_m[a] = N'($urandom);
      step(0, 0, 0, 1'b1, 2'(a), sh_m[a]);
    end
    step(0, 0, 1);
    w = N'($urandom);
    // Repeat commit plus a write, both in the copy cycle.
    step(0, 0, 1, 1'b1, 2'd2, w);
    @(negedge clk);
    vectors++;
    if (commit_pending !== 1'b1) begin
      miscompares++;
      $display("FAIL idle_commit_pending: got %b expected 1", commit_pending);
    end
    vectors++;
    if ({b0, b1, b2, b3} !== {act_m[0], act_m[1], act_m[2], act_m[3]}) begin
      miscompares++;
      $display("FAIL idle_commit_early: got %0d %0d %0d %0d expected %0d %0d %0d %0d",
               b0, b1, b2, b3, act_m[0], act_m[1], act_m[2], act_m[3]);
    end
    sh_m[2] = w;
    for (int i = 0; i < 4; i++) act_m[i] = sh_m[i];
    step(0, 0, 0);
    @(negedge clk);
    vectors++;
    if ({b0, b1, b2, b3} !== {act_m[0], act_m[1], act_m[2], act_m[3]}) begin
      miscompares++;
      $display("FAIL idle_commit_copy: got %0d %0d %0d %0d expected %0d %0d %0d %0d",
               b0, b1, b2, b3, act_m[0], act_m[1], act_m[2], act_m[3]);
    end
    vectors++;
    if (commit_pending !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_commit_clear: got %b expected 0", commit_pending);
    end
    step(0, 0, 0);
    @(negedge clk);
    vectors++;
    if (commit_pending !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_commit_absorb: got %b expected 0", commit_pending);
    end
  endtask

  task automatic test_commit_run();
    int t0;
    div = DW'(3);
    step(1, 0, 0);
    t0 = cyc;
    for (int a = 0; a < 4; a++) begin
      sh_m[a] = N'(a + 1);
      step(0, 0, 0, 1'b1, 2'(a), sh_m[a]);
    end
    // Advance to a tick cycle, then commit on the cycle after it (mid-period).
    while (((cyc - t0) % 4) != 0) step(0, 0, 0);
    step(0, 0, 1);
    for (int j = 1; j <= 4; j++) begin
      step(0, 0, 0);
      @(negedge clk);
      if (j < 4) begin
        vectors++;
        if (commit_pending !== 1'b1 ||
            {b0, b1, b2, b3} !== {act_m[0], act_m[1], act_m[2], act_m[3]}) begin
          miscompares++;
          $display("FAIL run_commit_hold c+%0d: got pend=%b b=%0d %0d %0d %0d expected pend=1 b=%0d %0d %0d %0d",
                   j, commit_pending, b0, b1, b2, b3, act_m[0], act_m[1], act_m[2], act_m[3]);
        end
      end else begin
        for (int i = 0; i < 4; i++) act_m[i] = sh_m[i];
        vectors++;
        if (commit_pending !== 1'b0 || fir_en !== 1'b1 ||
            {b0, b1, b2, b3} !== {act_m[0], act_m[1], act_m[2], act_m[3]}) begin
          miscompares++;
          $display("FAIL run_commit_apply: got pend=%b en=%b b=%0d %0d %0d %0d expected pend=0 en=1 b=1 2 3 4",
                   commit_pending, fir_en, b0, b1, b2, b3);
        end
      end
    end
    step(0, 1, 0);
    repeat (4 * 4 + 8) step(0, 0, 0);
  endtask

  task automatic test_start_stop_idle();
    step(1, 1, 0);
    for (int j = 0; j < 4; j++) begin
      step(0, 0, 0);
      @(negedge clk);
      vectors++;
      if (busy !== 1'b0 || fir_en !== 1'b0) begin
        miscompares++;
        $display("FAIL start_stop_idle c+%0d: got busy=%b en=%b expected 0 0", j + 1, busy, fir_en);
      end
    end
  endtask

  task automatic test_reset_mid();
    div = DW'(2);
    x_fixed_en = 1'b1;
    x_fixed    = N'(7);
    step(1, 0, 0);
    repeat (6) step(0, 0, 0);
    step(0, 1, 0);
    step(0, 0, 0);
    x_fixed_en = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    vectors++;
    if (fir_en !== 1'b0 || y_valid !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset_ctrl: got en=%b yv=%b busy=%b expected 0 0 0", fir_en, y_valid, busy);
    end
    vectors++;
    if (fir_x !== '0 || commit_pending !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset_data: got fir_x=%0d pend=%b expected 0 0", fir_x, commit_pending);
    end
    vectors++;
    if ({b0, b1, b2, b3} !== {N'(16), N'(0), N'(0), N'(0)}) begin
      miscompares++;
      $display("FAIL mid_reset_coef: got %0d %0d %0d %0d expected 16 0 0 0", b0, b1, b2, b3);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    // A commit straight after reset must copy the reset shadow bank.
    step(0, 0, 1);
    step(0, 0, 0);
    step(0, 0, 0);
    @(negedge clk);
    vectors++;
    if ({b0, b1, b2, b3} !== {act_m[0], act_m[1], act_m[2], act_m[3]} || commit_pending !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_shadow: got %0d %0d %0d %0d pend=%b expected 16 0 0 0 pend=0",
               b0, b1, b2, b3, commit_pending);
    end
    vectors++;
    if (busy !== 1'b0 || fir_x !== '0) begin
      miscompares++;
      $display("FAIL idle_hold: got busy=%b fir_x=%0d expected 0 0", busy, fir_x);
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    stop       = 1'b0;
    commit     = 1'b0;
    cfg_we     = 1'b0;
    cfg_addr   = 2'd0;
    cfg_wdata  = '0;
    div        = '0;
    x_in       = '0;
    x_fixed_en = 1'b0;
    x_fixed    = '0;

    test_reset();
    x_fixed_en = 1'b1;
    x_fixed    = N'(5);
    test_stream(3, 20, "div3_const5");
    x_fixed_en = 1'b0;
    test_stream(0, 10, "div0");
    for (int r = 0; r < 3; r++)
      test_stream(int'($urandom_range(1, 5)), int'($urandom_range(8, 30)), "div_rand");
    test_commit_idle();
    test_commit_run();
    test_start_stop_idle();
    test_reset_mid();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
